// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path types and constants.
// Used by instr_fetch and its fetch buffer.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: circular queue of {pc, instr} entries with flush.
// DEPTH is a power of two, so the pointers wrap naturally modulo DEPTH.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage is deliberately unreset; the head is don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register driving a combinational instruction source,
// feeding a small in-order buffer towards decode; redirects flush the buffer.
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full buffer still streams 1/cycle.
  assign push      = !redirect_valid && ((count < CW'(DEPTH)) || pop);

  assign push_data.pc    = pc_q;
  assign push_data.instr = imem_instr;

  always_ff @(posedge clk) begin
    if (!rst_n)              pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
    else if (redirect_valid) pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (push)           pc_q <= pc_q + 32'd4;
  end

  assign imem_addr = pc_q;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues the expected fetch stream,
// a negedge monitor pops and compares every accepted instruction.
module tb_instr_fetch;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  logic [31:0] w_imem_addr, w_imem_instr;
  logic        w_out_valid;
  logic [31:0] w_out_pc, w_out_instr;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign w_imem_instr = mem_word(w_imem_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_pc(w_out_pc), .out_instr(w_out_instr)
  );

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  fetch_entry_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [31:0] pc0, input int n);
    fetch_entry_t e;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.pc    = pc0 + 32'(4 * i);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: scoreboard pops on each accepted head, and stall stability checks.
  logic         hold_q = 1'b0;
  logic [31:0]  hold_pc, hold_instr;
  fetch_entry_t mon_e;

  always @(negedge clk) begin
    if (hold_q) begin
      chk("hold_valid", {31'b0, out_valid}, 32'h1);
      chk("hold_pc", out_pc, hold_pc);
      chk("hold_instr", out_instr, hold_instr);
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual_pc=%h required=no_output", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", out_pc, mon_e.pc);
        chk("sb_instr", out_instr, mon_e.instr);
      end
      pop_cnt++;
    end
    hold_q     = rst_n && out_valid && !out_ready && !redirect_valid;
    hold_pc    = out_pc;
    hold_instr = out_instr;
  end

  initial begin
    logic [31:0] wpc;
    int exp_pops;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset release with decode always ready; also the wrap-around instance.
    start_stream(32'h0, 64);
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("w_rst_addr", w_imem_addr, 32'hFFFF_FFF8);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", {31'b0, out_valid}, 32'h1);
      chk("t1_pc", out_pc, 32'(4 * k));
      chk("t1_instr", out_instr, mem_word(32'(4 * k)));
      wpc = 32'hFFFF_FFF8 + 32'(4 * k);
      chk("wrap_pc", w_out_pc, wpc);
      chk("wrap_instr", w_out_instr, mem_word(wpc));
      step();
    end

    // Decode stalled from reset: buffer fills, PC stops at 0x8.
    rst_n = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    start_stream(32'h0, 64);
    rst_n = 1'b1;
    repeat (4) step();
    chk("stall_valid", {31'b0, out_valid}, 32'h1);
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc", out_pc, 32'h0);
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("drain_valid", {31'b0, out_valid}, 32'h1);
      chk("drain_pc", out_pc, 32'(4 * k));
      step();
    end

    // Full buffer held, then redirect to a misaligned target.
    out_ready = 1'b0;
    step();
    step();
    chk("full_addr", imem_addr, 32'h14);
    chk("full_pc", out_pc, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    start_stream(32'h40, 64);
    chk("redir_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    step();
    chk("redir_valid2", {31'b0, out_valid}, 32'h1);
    chk("redir_pc", out_pc, 32'h40);
    chk("redir_instr", out_instr, mem_word(32'h40));
    out_ready = 1'b1;
    repeat (3) step();

    // Redirect coincident with a pop: head consumed, old stream must not resume.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0101;
    step();
    redirect_valid = 1'b0;
    start_stream(32'h100, 64);
    chk("redir2_valid", {31'b0, out_valid}, 32'h0);
    chk("redir2_addr", imem_addr, 32'h100);
    repeat (5) step();

    // Reset overrides a simultaneous redirect while the buffer is occupied.
    out_ready = 1'b0;
    repeat (2) step();
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    chk("rst2_valid", {31'b0, out_valid}, 32'h0);
    chk("rst2_addr", imem_addr, 32'h0);
    redirect_valid = 1'b0;
    start_stream(32'h0, 64);
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (5) step();

    // Random decode back-pressure: stream must come out complete and in order.
    rst_n = 1'b0;
    out_ready = 1'b0;
    step();
    start_stream(32'h0, 1100);
    pop_cnt  = 0;
    exp_pops = 0;
    rst_n = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (c >= 2) begin
        if (out_ready) exp_pops++;
        chk("rnd_valid", {31'b0, out_valid}, 32'h1);
      end
      step();
    end
    out_ready = 1'b0;
    step();
    chk("rnd_pops", 32'(pop_cnt), 32'(exp_pops));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
